// File: rtl/sensor_result_buf_pkg.sv
// Shared definitions for the sensor result buffer: register offsets, CMD bits
// and the STATUS byte layout.
package sensor_buf_pkg;

    localparam logic [3:0] REG_STATUS  = 4'h0;
    localparam logic [3:0] REG_DATA_LO = 4'h1;
    localparam logic [3:0] REG_DATA_HI = 4'h2;
    localparam logic [3:0] REG_ERR_CNT = 4'h3;
    localparam logic [3:0] REG_OVF_CNT = 4'h4;
    localparam logic [3:0] REG_AVG_LO  = 4'h5;
    localparam logic [3:0] REG_AVG_HI  = 4'h6;
    localparam logic [3:0] REG_AVG_CNT = 4'h7;
    localparam logic [3:0] REG_CMD     = 4'h8;

    localparam int CMD_CLEAR_BIT = 0;
    localparam int CMD_FIRE_BIT  = 1;

    typedef struct packed {
        logic       full;
        logic       empty;
        logic       ovf;
        logic [4:0] count;
    } status_t;

    // 8-bit event counters stick at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sensor_result_buf_if.sv
// Measurement-result and fx host-bus signals between sensor_core/commu_top and
// the result buffer.
interface sensor_result_buf_if;

    logic        done_measure;
    logic        err_measure;
    logic [15:0] data_measure;
    logic        fire_measure;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;
    logic        irq_nempty;

    modport master (
        output done_measure, err_measure, data_measure,
        output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        input  fire_measure, fx_q, irq_nempty
    );

    modport slave (
        input  done_measure, err_measure, data_measure,
        input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        output fire_measure, fx_q, irq_nempty
    );

endinterface

// File: rtl/sensor_result_buf_res_fifo.sv
// Synchronous result FIFO with clear; head is read combinationally at rd_ptr.
module res_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr,
    input  logic [WIDTH-1:0]      din,
    output logic                  pushed,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [WIDTH-1:0]      head
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  popped;

    // Count never exceeds DEPTH, so its top bit alone flags a full FIFO.
    assign full   = count_q[DEPTH_LOG2];
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign popped = pop && !empty && !clr;
    assign pushed = push && !clr && (!full || popped);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pushed) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (popped) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({pushed, popped})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushed) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sensor_result_buf.sv
// Result buffer: queues sensor measurements and serves them as fx registers.
// Optional running-mean registers are built when SENSOR_AVG_EN is defined.
module sensor_result_buf
    import sensor_buf_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR  = 22'h000200,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    sensor_result_buf_if.slave bus
);

    logic                rd_sel, wr_cmd, clr, pop, sample_vld, err_evt;
    logic [3:0]          rd_off;
    logic                fifo_full, fifo_empty, fifo_pushed;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [15:0]         fifo_head;
    logic [7:0]          err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;
    logic [7:0]          shadow_q, shadow_d, fx_q_q, fx_q_d, rdata;
    logic                fire_q, fire_d;
    logic [7:0]          avg_lo_rd, avg_hi_rd, avg_cnt_rd;
    status_t             status;

    assign rd_sel     = bus.fx_rd && (bus.fx_raddr[21:4] == BASE_ADDR[21:4]);
    assign rd_off     = bus.fx_raddr[3:0];
    assign wr_cmd     = bus.fx_wr && (bus.fx_waddr[21:4] == BASE_ADDR[21:4])
                        && (bus.fx_waddr[3:0] == REG_CMD);
    assign clr        = wr_cmd && bus.fx_data[CMD_CLEAR_BIT];
    assign fire_d     = wr_cmd && bus.fx_data[CMD_FIRE_BIT];
    assign pop        = rd_sel && (rd_off == REG_DATA_HI);
    assign sample_vld = bus.done_measure && !bus.err_measure;
    assign err_evt    = bus.done_measure && bus.err_measure;

    res_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(16)) u_fifo (
        .clk    (clk_sys),
        .rst_n  (rst_n),
        .push   (sample_vld),
        .pop    (pop),
        .clr    (clr),
        .din    (bus.data_measure),
        .pushed (fifo_pushed),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count),
        .head   (fifo_head)
    );

    always_comb begin
        status       = '0;
        status.full  = fifo_full;
        status.empty = fifo_empty;
        status.ovf   = (ovf_cnt_q != 8'h00);
        status.count = 5'(fifo_count);
    end

    // A valid sample the FIFO refused (full, no pop, no clear) counts as overflow.
    always_comb begin
        err_cnt_d = err_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        shadow_d  = shadow_q;
        if (clr) begin
            err_cnt_d = 8'h00;
            ovf_cnt_d = 8'h00;
        end else begin
            if (err_evt) err_cnt_d = sat_inc8(err_cnt_q);
            if (sample_vld && !fifo_pushed) ovf_cnt_d = sat_inc8(ovf_cnt_q);
        end
        if (rd_sel && (rd_off == REG_DATA_LO)) begin
            shadow_d = fifo_empty ? 8'h00 : fifo_head[15:8];
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (rd_off)
            REG_STATUS:  rdata = status;
            REG_DATA_LO: rdata = fifo_empty ? 8'h00 : fifo_head[7:0];
            REG_DATA_HI: rdata = shadow_q;
            REG_ERR_CNT: rdata = err_cnt_q;
            REG_OVF_CNT: rdata = ovf_cnt_q;
            REG_AVG_LO:  rdata = avg_lo_rd;
            REG_AVG_HI:  rdata = avg_hi_rd;
            REG_AVG_CNT: rdata = avg_cnt_rd;
            default:     rdata = 8'h00;
        endcase
        fx_q_d = rd_sel ? rdata : 8'h00;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
            ovf_cnt_q <= 8'h00;
            shadow_q  <= 8'h00;
            fx_q_q    <= 8'h00;
            fire_q    <= 1'b0;
        end else begin
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
            shadow_q  <= shadow_d;
            fx_q_q    <= fx_q_d;
            fire_q    <= fire_d;
        end
    end

`ifdef SENSOR_AVG_EN
    logic [15:0] avg_win_q [4];
    logic [2:0]  avg_cnt_q;
    logic [7:0]  avg_shadow_q;
    logic [17:0] avg_sum;
    logic [15:0] avg_mean;

    // Empty window slots hold zero, so the mean always divides by four.
    assign avg_sum  = 18'(avg_win_q[0]) + 18'(avg_win_q[1])
                    + 18'(avg_win_q[2]) + 18'(avg_win_q[3]);
    assign avg_mean = 16'(avg_sum >> 2);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) avg_win_q[i] <= 16'h0000;
            avg_cnt_q    <= 3'd0;
            avg_shadow_q <= 8'h00;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) avg_win_q[i] <= 16'h0000;
            avg_cnt_q    <= 3'd0;
            avg_shadow_q <= 8'h00;
        end else begin
            if (fifo_pushed) begin
                avg_win_q[0] <= bus.data_measure;
                for (int i = 1; i < 4; i++) avg_win_q[i] <= avg_win_q[i-1];
                if (avg_cnt_q != 3'd4) avg_cnt_q <= avg_cnt_q + 3'd1;
            end
            if (rd_sel && (rd_off == REG_AVG_LO)) avg_shadow_q <= avg_mean[15:8];
        end
    end

    assign avg_lo_rd  = avg_mean[7:0];
    assign avg_hi_rd  = avg_shadow_q;
    assign avg_cnt_rd = {5'd0, avg_cnt_q};
`else
    assign avg_lo_rd  = 8'h00;
    assign avg_hi_rd  = 8'h00;
    assign avg_cnt_rd = 8'h00;
`endif

    assign bus.fx_q         = fx_q_q;
    assign bus.fire_measure = fire_q;
    assign bus.irq_nempty   = !fifo_empty;

endmodule
